// File: rtl/divider_arbiter_if.sv
// Requester, divider and result bundle for divider_arbiter.
// slave is the arbiter side; master is the requester/divider side.
interface divider_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int OUTSIZE = 20
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    i_reqValid;
  logic [NREQ*32-1:0] i_numerator;
  logic [NREQ*22-1:0] i_denominator;
  logic [NREQ-1:0]    o_reqGrant;
  logic [31:0]        o_divNumerator;
  logic [21:0]        o_divDenominator;
  logic [OUTSIZE-1:0] i_divQuotient;
  logic               o_resValid;
  logic [IDW-1:0]     o_resId;
  logic [OUTSIZE-1:0] o_quotient;
  logic               o_busy;

  modport slave (
    input  i_reqValid,
    input  i_numerator,
    input  i_denominator,
    input  i_divQuotient,
    output o_reqGrant,
    output o_divNumerator,
    output o_divDenominator,
    output o_resValid,
    output o_resId,
    output o_quotient,
    output o_busy
  );

  modport master (
    output i_reqValid,
    output i_numerator,
    output i_denominator,
    output i_divQuotient,
    input  o_reqGrant,
    input  o_divNumerator,
    input  o_divDenominator,
    input  o_resValid,
    input  o_resId,
    input  o_quotient,
    input  o_busy
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one pipelined signed divider.
// DIVARB_ZERO_DETECT_EN: saturate quotients of divide-by-zero ops.
module divider_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 6,
  parameter int OUTSIZE = 20
) (
  input logic              clock,
  input logic              reset,
  divider_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic           v;
`ifdef DIVARB_ZERO_DETECT_EN
    logic           dz;
    logic           neg;
`endif
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] last;
  logic [IDW-1:0] sel;
  logic           hit;
  logic [31:0]    num_sel;
  logic [21:0]    den_sel;
  logic [31:0]    num_q;
  logic [21:0]    den_q;
  logic           busy;
  tag_t           new_tag;
  tag_t           out_tag;
  tag_t           tags [LATENCY];

  // First pending requester after last, wrapping.
  always_comb begin
    hit = 1'b0;
    sel = last;
    for (int i = 1; i <= NREQ; i++) begin
      if (!hit &&
          bus.i_reqValid[(int'(last) + i) % NREQ]) begin
        hit = 1'b1;
        sel = IDW'((int'(last) + i) % NREQ);
      end
    end
  end

  always_comb begin
    bus.o_reqGrant = '0;
    if (hit && !reset)
      bus.o_reqGrant[sel] = 1'b1;
  end

  assign num_sel = bus.i_numerator[32*sel +: 32];
  assign den_sel = bus.i_denominator[22*sel +: 22];

  always_comb begin
    new_tag = '0;
    if (hit) begin
      new_tag.v  = 1'b1;
      new_tag.id = sel;
`ifdef DIVARB_ZERO_DETECT_EN
      new_tag.dz  = (den_sel == '0);
      new_tag.neg = num_sel[31];
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last    <= IDW'(NREQ - 1);
      num_q   <= '0;
      den_q   <= '0;
      out_tag <= '0;
      for (int k = 0; k < LATENCY; k++)
        tags[k] <= '0;
    end else begin
      if (hit) begin
        last  <= sel;
        num_q <= num_sel;
        den_q <= den_sel;
      end
      tags[0] <= new_tag;
      for (int k = 1; k < LATENCY; k++)
        tags[k] <= tags[k-1];
      out_tag <= tags[LATENCY-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++)
      busy = busy | tags[k].v;
  end

  assign bus.o_divNumerator   = num_q;
  assign bus.o_divDenominator = den_q;
  assign bus.o_resValid       = out_tag.v;
  assign bus.o_resId          = out_tag.id;
  assign bus.o_busy           = busy;

`ifdef DIVARB_ZERO_DETECT_EN
  logic [OUTSIZE-1:0] sat;

  assign sat = out_tag.neg ?
    {1'b1, {(OUTSIZE-1){1'b0}}} :
    {1'b0, {(OUTSIZE-1){1'b1}}};
  assign bus.o_quotient = out_tag.dz ?
    sat : bus.i_divQuotient;
`else
  assign bus.o_quotient = bus.i_divQuotient;
`endif
endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural
// pipelined divider model hanging off the div ports.
module tb_divider_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 6;
  localparam int OSZ  = 20;

  typedef struct packed {
    logic [1:0]  id;
    logic [19:0] q;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [3:0]  rv;
  logic [31:0] nums [NREQ];
  logic [21:0] dens [NREQ];
  logic [19:0] dq   [LAT];
  int          n_vec;
  int          n_err;
  int          cyc;
  int          res_cnt;
  int          res_cyc [$];
  exp_t        sb [$];

  divider_arbiter_if #(.NREQ(NREQ), .OUTSIZE(OSZ)) bus ();

  divider_arbiter #(
    .NREQ(NREQ), .LATENCY(LAT), .OUTSIZE(OSZ)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  always_comb begin
    bus.i_reqValid    = rv;
    bus.i_numerator   = '0;
    bus.i_denominator = '0;
    for (int k = 0; k < NREQ; k++) begin
      bus.i_numerator[32*k +: 32]   = nums[k];
      bus.i_denominator[22*k +: 22] = dens[k];
    end
  end

  function automatic logic [19:0] div_model(
    input logic [31:0] n, input logic [21:0] d);
    logic signed [31:0] sn, sd, sq;
    if (d == '0) return 20'h5A5A5;
    sn = n;
    sd = {{10{d[21]}}, d};
    sq = sn / sd;
    return sq[19:0];
  endfunction

  function automatic logic [19:0] exp_q(
    input logic [31:0] n, input logic [21:0] d);
`ifdef DIVARB_ZERO_DETECT_EN
    if (d == '0) return n[31] ? 20'h80000 : 20'h7FFFF;
`endif
    return div_model(n, d);
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    dq[0] <= div_model(bus.o_divNumerator,
                       bus.o_divDenominator);
    for (int k = 1; k < LAT; k++) dq[k] <= dq[k-1];
  end
  assign bus.i_divQuotient = dq[LAT-1];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.o_resValid === 1'b1) begin
      exp_t e;
      res_cnt++;
      res_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_id", 32'(bus.o_resId), 32'(e.id));
        chk("sb_quot", 32'(bus.o_quotient), 32'(e.q));
      end
    end
  end

  // Drive the mask, then see who is granted at the coming edge.
  task automatic issue(input logic [3:0] mask,
                       output logic [3:0] g);
    rv = mask;
    #1;
    g = bus.o_reqGrant;
    for (int k = 0; k < NREQ; k++)
      if (g[k]) sb.push_back({2'(k), exp_q(nums[k], dens[k])});
  endtask

  task automatic new_ops(input int k);
    int d;
    nums[k] = $urandom;
    d = $urandom_range(1, 150000);
    dens[k] = ($urandom_range(0, 1) == 1) ? 22'(-d) : 22'(d);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rv = '0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic single_op(input int k,
                           input logic [31:0] n,
                           input logic [21:0] d,
                           input logic [19:0] q);
    logic [3:0] g;
    @(negedge clock);
    nums[k] = n;
    dens[k] = d;
    issue(4'(1 << k), g);
    chk("op_grant", 32'(g), 32'(1 << k));
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge clock);
      rv = '0;
      #1;
      chk("op_busy", 32'(bus.o_busy), 32'(j <= LAT));
      chk("op_valid", 32'(bus.o_resValid),
          32'(j == LAT + 1));
      if (j == 1) begin
        chk("op_num", bus.o_divNumerator, n);
        chk("op_den", 32'(bus.o_divDenominator), 32'(d));
      end
      if (j == LAT + 1) begin
        chk("op_id", 32'(bus.o_resId), k);
        chk("op_quot", 32'(bus.o_quotient), 32'(q));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    int base;
    clock = 1'b0;
    reset = 1'b0;
    rv = '0;
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    res_cnt = 0;
    for (int k = 0; k < NREQ; k++) begin
      nums[k] = '0;
      dens[k] = '0;
    end
    #1 reset = 1'b1;
    rv = 4'hF;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_grant", 32'(bus.o_reqGrant), 0);
    chk("rst_num", bus.o_divNumerator, 0);
    chk("rst_den", 32'(bus.o_divDenominator), 0);
    chk("rst_valid", 32'(bus.o_resValid), 0);
    chk("rst_id", 32'(bus.o_resId), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    rv = '0;
    @(negedge clock);
    reset = 1'b0;

    single_op(2, 32'd1000, 22'd7, 20'd142);
    single_op(1, -32'sd1000, 22'd7, 20'hFFF72);

    // Round robin from reset pointer.
    do_reset();
    for (int k = 0; k < NREQ; k++) new_ops(k);
    base = res_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i > 0) new_ops((i - 1) % NREQ);
      issue(4'hF, g);
      chk("rr_grant", 32'(g), 32'(1 << (i % NREQ)));
    end
    repeat (LAT + 4) begin
      @(negedge clock);
      rv = '0;
    end
    #1;
    chk("rr_count", res_cnt - base, 8);
    if (res_cnt - base == 8)
      chk("rr_span", res_cyc[base+7] - res_cyc[base], 7);

    // Lone requester is granted every cycle.
    base = res_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      new_ops(1);
      issue(4'b0010, g);
      chk("solo_grant", 32'(g), 32'b0010);
    end
    repeat (LAT + 4) begin
      @(negedge clock);
      rv = '0;
    end
    #1;
    chk("solo_count", res_cnt - base, 4);

`ifdef DIVARB_ZERO_DETECT_EN
    single_op(0, 32'd500, 22'd0, 20'h7FFFF);
    single_op(3, -32'sd500, 22'd0, 20'h80000);
`else
    single_op(0, 32'd500, 22'd0, 20'h5A5A5);
    single_op(3, -32'sd500, 22'd0, 20'h5A5A5);
`endif

    // Reset with three ops in flight drops them all.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      new_ops(k);
      issue(4'(1 << k), g);
    end
    repeat (3) begin
      @(negedge clock);
      rv = '0;
    end
    reset = 1'b1;
    #1;
    chk("mid_busy", 32'(bus.o_busy), 0);
    chk("mid_valid", 32'(bus.o_resValid), 0);
    sb.delete();
    base = res_cnt;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (LAT + 6) @(negedge clock);
    chk("mid_none", res_cnt - base, 0);

    // Pointer is 3 after reset; requester 1 retracts.
    for (int k = 0; k < NREQ; k++) new_ops(k);
    @(negedge clock);
    issue(4'b0011, g);
    chk("ptr_g0", 32'(g), 32'b0001);
    @(negedge clock);
    issue(4'b0000, g);
    chk("ptr_retract", 32'(g), 0);
    @(negedge clock);
    issue(4'b0000, g);
    chk("ptr_idle", 32'(g), 0);
    @(negedge clock);
    issue(4'b1110, g);
    chk("ptr_after0", 32'(g), 32'b0010);
    @(negedge clock);
    issue(4'b1001, g);
    chk("ptr_after1", 32'(g), 32'b1000);
    @(negedge clock);
    issue(4'b0001, g);
    chk("ptr_wrap", 32'(g), 32'b0001);
    repeat (LAT + 4) begin
      @(negedge clock);
      rv = '0;
    end
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
